// File: rtl/regfile_store_32x64.sv
// regfile_store_32x64: storage half of the LEGv8 register file.
// DEPTH-1 flop registers plus a hardwired zero register at index DEPTH-1. It
// has a single write port and a sequential bulk-clear sweep. Every register is
// presented in parallel on regs_out for the downstream read muxes.
module regfile_store_32x64 #(
  parameter int WIDTH  = 64,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [WIDTH-1:0]  WriteData,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              wr_drop,
  output logic [WIDTH-1:0]  regs_out [DEPTH]
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  // Index of the zero register, and the last index the sweep clears.
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 2);

  // Only DEPTH-1 real registers; the zero register has no storage.
  logic [WIDTH-1:0]  regs_q [DEPTH-1];
  logic [WIDTH-1:0]  regs_d [DEPTH-1];

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              wr_drop_q, wr_drop_d;

  logic              wr_valid;
  logic              wr_commit;

  // A write aimed at any real register.
  always_comb begin
    wr_valid  = RegWrite && (WriteRegister != ZERO_IDX);
    wr_commit = wr_valid && (state_q == ST_IDLE);
  end

  // Sweep controller: the IDLE/CLEAR transitions and the clear counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        // clr_req is ignored here: there is no restart and no queueing.
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A write that arrives during the sweep is discarded and flagged next cycle.
  always_comb begin
    wr_drop_d = wr_valid && (state_q == ST_CLEAR);
  end

  // Register next-state logic: the write decoder in IDLE, the sweep zeroing in CLEAR.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH - 1; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_commit && (WriteRegister == ADDR_W'(i))) begin
        regs_d[i] = WriteData;
      end
      if ((state_q == ST_CLEAR) && (cnt_q == ADDR_W'(i))) begin
        regs_d[i] = '0;
      end
    end
  end

  // Control state flops; an asynchronous reset aborts any sweep in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // Register storage; an asynchronous reset forces every register to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH - 1; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH - 1; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Parallel output bus; the zero register is a constant.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH - 1; i++) begin
      regs_out[i] = regs_q[i];
    end
    regs_out[DEPTH-1] = '0;
  end

  // Busy is exactly the CLEAR state, so it needs no separate flop.
  always_comb begin
    clr_busy = (state_q == ST_CLEAR);
    wr_drop  = wr_drop_q;
  end

endmodule

// File: tb/tb_regfile_store_32x64.sv
// tb_regfile_store_32x64: directed-vector bench for regfile_store_32x64.
// Inputs change on the falling edge. Outputs are sampled 1 ns after the rising edge.
module tb_regfile_store_32x64;

  localparam int WIDTH  = 64;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              reset;
  logic              RegWrite;
  logic [ADDR_W-1:0] WriteRegister;
  logic [WIDTH-1:0]  WriteData;
  logic              clr_req;
  logic              clr_busy;
  logic              wr_drop;
  logic [WIDTH-1:0]  regs_out [DEPTH];

  int errors = 0;
  int checks = 0;
  int busy_cycles;

  regfile_store_32x64 #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .RegWrite     (RegWrite),
    .WriteRegister(WriteRegister),
    .WriteData    (WriteData),
    .clr_req      (clr_req),
    .clr_busy     (clr_busy),
    .wr_drop      (wr_drop),
    .regs_out     (regs_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("%s_x%0d", tag, i), regs_out[i], 64'h0);
    end
  endtask

  initial begin
    reset         = 1'b1;
    RegWrite      = 1'b0;
    WriteRegister = '0;
    WriteData     = '0;
    clr_req       = 1'b0;

    // 1. Reset state
    repeat (2) @(negedge clk);
    reset = 1'b0;
    step();
    check_all_zero("rst");
    check("rst_busy", 64'(clr_busy), 64'h0);
    check("rst_drop", 64'(wr_drop), 64'h0);

    // 2. Write X5, with no same-cycle bypass
    @(negedge clk);
    RegWrite      = 1'b1;
    WriteRegister = 5'd5;
    WriteData     = 64'hDEAD_BEEF_0123_4567;
    #1;
    check("x5_nobypass", regs_out[5], 64'h0);
    step();
    check("x5_written", regs_out[5], 64'hDEAD_BEEF_0123_4567);
    for (int i = 0; i < DEPTH; i++) begin
      if (i != 5) check($sformatf("x5_other_x%0d", i), regs_out[i], 64'h0);
    end

    // 3. A write to X31 is ignored and is not flagged
    @(negedge clk);
    WriteRegister = 5'd31;
    WriteData     = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    check("x31_zero", regs_out[31], 64'h0);
    check("x31_nodrop", 64'(wr_drop), 64'h0);
    check("x31_x5_kept", regs_out[5], 64'hDEAD_BEEF_0123_4567);
    @(negedge clk);
    RegWrite = 1'b0;
    step();
    check("x31_nodrop2", 64'(wr_drop), 64'h0);

    // 4. Fill X0..X30 with i+1, then sweep
    for (int i = 0; i < DEPTH - 1; i++) begin
      @(negedge clk);
      RegWrite      = 1'b1;
      WriteRegister = 5'(i);
      WriteData     = 64'(i + 1);
      step();
    end
    @(negedge clk);
    RegWrite = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      check($sformatf("fill_x%0d", i), regs_out[i], 64'(i + 1));
    end
    check("fill_x31", regs_out[31], 64'h0);
    clr_req = 1'b1;
    step();                                  // sweep edge 0
    check("sw_busy_e0", 64'(clr_busy), 64'h1);
    check("sw_x0_e0", regs_out[0], 64'h1);
    busy_cycles = clr_busy ? 1 : 0;
    @(negedge clk);
    clr_req = 1'b0;
    for (int k = 1; k <= DEPTH - 1; k++) begin
      step();                                // sweep edge k
      check($sformatf("sw_clr_x%0d", k - 1), regs_out[k - 1], 64'h0);
      if (k < DEPTH - 1) begin
        check($sformatf("sw_keep_x%0d", k), regs_out[k], 64'(k + 1));
      end
      if (clr_busy) busy_cycles++;
    end
    check("sw_busy_count", 64'(busy_cycles), 64'd31);
    check("sw_busy_end", 64'(clr_busy), 64'h0);
    check_all_zero("sw_end");

    // 5. Writes during the sweep are dropped, and clr_req is ignored
    @(negedge clk);
    RegWrite      = 1'b1;
    WriteRegister = 5'd3;
    WriteData     = 64'h55;
    step();
    check("d_x3_pre", regs_out[3], 64'h55);
    @(negedge clk);
    RegWrite = 1'b0;
    clr_req  = 1'b1;
    step();                                  // edge 0
    @(negedge clk);
    clr_req       = 1'b0;
    RegWrite      = 1'b1;
    WriteRegister = 5'd3;
    WriteData     = 64'h1234;
    step();                                  // edge 1
    check("d_x3_not_written", regs_out[3], 64'h55);
    check("d_drop_e1", 64'(wr_drop), 64'h1);
    @(negedge clk);
    WriteRegister = 5'd7;
    WriteData     = 64'h99;
    clr_req       = 1'b1;
    step();                                  // edge 2
    check("d_drop_b2b", 64'(wr_drop), 64'h1);
    check("d_x7_not_written", regs_out[7], 64'h0);
    check("d_busy_e2", 64'(clr_busy), 64'h1);
    @(negedge clk);
    clr_req       = 1'b0;
    WriteRegister = 5'd31;
    step();                                  // edge 3
    check("d_x31_nodrop", 64'(wr_drop), 64'h0);
    @(negedge clk);
    RegWrite = 1'b0;
    step();                                  // edge 4
    check("d_x3_swept", regs_out[3], 64'h0);
    check("d_drop_low", 64'(wr_drop), 64'h0);
    repeat (26) step();                      // edge 30
    check("d_busy_e30", 64'(clr_busy), 64'h1);
    step();                                  // edge 31
    check("d_no_restart", 64'(clr_busy), 64'h0);

    // 6. Write and clr_req in one cycle, then asynchronous reset mid-sweep
    @(negedge clk);
    RegWrite      = 1'b1;
    WriteRegister = 5'd20;
    WriteData     = 64'h77;
    clr_req       = 1'b1;
    step();                                  // edge 0
    check("r_x20_written", regs_out[20], 64'h77);
    check("r_busy", 64'(clr_busy), 64'h1);
    @(negedge clk);
    RegWrite = 1'b0;
    clr_req  = 1'b0;
    repeat (10) step();                      // edge 10
    check("r_x9_swept", regs_out[9], 64'h0);
    check("r_x20_held", regs_out[20], 64'h77);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("r_async_x20", regs_out[20], 64'h0);
    check("r_async_busy", 64'(clr_busy), 64'h0);
    check("r_async_drop", 64'(wr_drop), 64'h0);
    check_all_zero("r_async");
    @(negedge clk);
    reset = 1'b0;
    step();
    check("r_idle_busy", 64'(clr_busy), 64'h0);
    @(negedge clk);
    RegWrite      = 1'b1;
    WriteRegister = 5'd2;
    WriteData     = 64'hABC;
    step();
    check("r_idle_write", regs_out[2], 64'hABC);
    check("r_idle_nodrop", 64'(wr_drop), 64'h0);
    @(negedge clk);
    RegWrite = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
